// File: rtl/bird_pkg.sv
// Shared encodings for the bird control FSM and its datapath: control states,
// direction latch values, colours, screen bounds and plot port widths.
package bird_pkg;

    localparam logic [3:0] B_START   = 4'd0;
    localparam logic [3:0] B_RAISING = 4'd1;
    localparam logic [3:0] B_FALLING = 4'd2;
    localparam logic [3:0] B_STOP    = 4'd3;
    localparam logic [3:0] B_DRAW    = 4'd4;

    typedef enum logic [1:0] {
        DIR_HOLD = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    localparam int unsigned COLOUR_W = 3;
    localparam logic [COLOUR_W-1:0] COL_BIRD = 3'b110;
    localparam logic [COLOUR_W-1:0] COL_BG   = 3'b000;

    localparam int unsigned SCREEN_TOP    = 0;
    localparam int unsigned SCREEN_BOTTOM = 116;

    localparam int unsigned X_W = 8;
    localparam int unsigned Y_W = 7;

endpackage

// File: rtl/sprite_scan.sv
// SIZE x SIZE row-major cell counter; exposes next-cycle row/col so the
// owner can register plot coordinates in step with the scan.
module sprite_scan #(
    parameter int unsigned SIZE = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic [$clog2(SIZE)-1:0]   row_nx_c,
    output logic [$clog2(SIZE)-1:0]   col_nx_c,
    output logic                      done_c
);

    localparam int unsigned SW = $clog2(SIZE);
    localparam int unsigned CW = 2 * SW;
    localparam logic [CW-1:0] LAST = CW'(SIZE * SIZE - 1);

    logic [CW-1:0] cnt, cnt_nx;
    logic          active, active_nx;

    assign done_c = active && (cnt == LAST);

    always_comb begin
        cnt_nx    = cnt;
        active_nx = active;
        if (start) begin
            cnt_nx    = '0;
            active_nx = 1'b1;
        end else if (active) begin
            if (done_c) begin
                active_nx = 1'b0;
            end else begin
                cnt_nx = cnt + CW'(1);
            end
        end
    end

    assign row_nx_c = cnt_nx[CW-1:SW];
    assign col_nx_c = cnt_nx[SW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            active <= 1'b0;
        end else begin
            cnt    <= cnt_nx;
            active <= active_nx;
        end
    end

endmodule

// File: rtl/bird_datapath.sv
// Bird vertical-position datapath: erase/move/redraw of the sprite per frame tick.
// Define BIRD_GRAVITY_EN for an accelerating fall (step grows by 1 per move, max 4).
module bird_datapath
    import bird_pkg::*;
#(
    parameter int unsigned X_POS      = 20,
    parameter int unsigned START_Y    = 60,
    parameter int unsigned SIZE       = 4,
    parameter int unsigned STEP       = 1,
    parameter int unsigned RISE_LIMIT = 12,
    parameter int unsigned TOP_Y      = SCREEN_TOP,
    parameter int unsigned BOTTOM_Y   = SCREEN_BOTTOM,
    parameter logic [COLOUR_W-1:0] BIRD_COLOUR = COL_BIRD,
    parameter logic [COLOUR_W-1:0] BG_COLOUR   = COL_BG
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          state,
    input  logic                frame_tick,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                flag,
    output logic                hit_floor,
    output logic                busy,
    output logic [Y_W-1:0]      bird_y
);

    localparam int unsigned SW = $clog2(SIZE);
    localparam int unsigned RW = Y_W + 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ERASE    = 2'd1;
    localparam logic [1:0] S_UPDATE   = 2'd2;
    localparam logic [1:0] S_DRAW_SPR = 2'd3;

    logic [1:0]          fsm, fsm_nx;
    dir_t                dir, dir_nx;
    logic                repos, repos_nx;
    logic                pending, pending_nx;
    logic [Y_W-1:0]      rise_cnt, rise_nx;
    logic                flag_nx;
    logic [Y_W-1:0]      bird_y_nx;
    logic                tick_ok;
    logic                repos_req;

    logic                plot_nx, busy_nx;
    logic [X_W-1:0]      x_nx;
    logic [Y_W-1:0]      y_nx;
    logic [COLOUR_W-1:0] colour_nx;

    logic                scan_start, scan_done_c;
    logic [SW-1:0]       scan_row_c, scan_col_c;

    logic [Y_W-1:0]      up_y, moved, dn_y;
    logic [RW-1:0]       rise_sum, dn_sum;
    logic [2:0]          down_step;

    // Clamped move arithmetic, one bit wider so nothing wraps at row 0 or 127
    assign up_y     = ({1'b0, bird_y} < RW'(TOP_Y + STEP)) ? Y_W'(TOP_Y)
                                                          : bird_y - Y_W'(STEP);
    assign moved    = bird_y - up_y;
    assign rise_sum = {1'b0, rise_cnt} + {1'b0, moved};
    assign dn_sum   = {1'b0, bird_y} + RW'(down_step);
    assign dn_y     = (dn_sum > RW'(BOTTOM_Y)) ? Y_W'(BOTTOM_Y) : dn_sum[Y_W-1:0];

    assign repos_req = repos || (state == B_START);
    assign hit_floor = (bird_y == Y_W'(BOTTOM_Y));

`ifdef BIRD_GRAVITY_EN
    localparam logic [2:0] GRAV_MAX = 3'd4;
    logic [2:0] grav_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            grav_step <= 3'(STEP);
        end else if (state == B_RAISING || state == B_START) begin
            grav_step <= 3'(STEP);
        end else if (fsm == S_UPDATE && !repos && dir == DIR_DOWN && grav_step < GRAV_MAX) begin
            grav_step <= grav_step + 3'd1;
        end
    end

    assign down_step = grav_step;
`else
    assign down_step = 3'(STEP);
`endif

    // Sequencer, direction latch and position update
    always_comb begin
        fsm_nx     = fsm;
        pending_nx = pending;
        dir_nx     = dir;
        repos_nx   = repos;
        rise_nx    = rise_cnt;
        flag_nx    = flag;
        bird_y_nx  = bird_y;
        scan_start = 1'b0;
        tick_ok    = 1'b0;

        if (fsm == S_UPDATE) begin
            repos_nx = 1'b0;
            if (repos) begin
                bird_y_nx = Y_W'(START_Y);
            end else if (dir == DIR_UP) begin
                bird_y_nx = up_y;
                rise_nx   = rise_sum[Y_W] ? '1 : rise_sum[Y_W-1:0];
                if (rise_sum >= RW'(RISE_LIMIT) || up_y == Y_W'(TOP_Y)) begin
                    flag_nx = 1'b1;
                end
            end else if (dir == DIR_DOWN) begin
                bird_y_nx = dn_y;
            end
        end

        // Clears from the control state take priority over the update above
        case (state)
            B_RAISING: dir_nx = DIR_UP;
            B_FALLING: begin
                dir_nx  = DIR_DOWN;
                rise_nx = '0;
                flag_nx = 1'b0;
            end
            B_STOP:    dir_nx = DIR_HOLD;
            B_START: begin
                dir_nx   = DIR_HOLD;
                rise_nx  = '0;
                flag_nx  = 1'b0;
                repos_nx = 1'b1;
            end
            B_DRAW:    ;
            default:   ;
        endcase

        tick_ok = frame_tick && (state != B_STOP) && (dir_nx != DIR_HOLD || repos_req);

        case (fsm)
            S_IDLE: begin
                if (pending || tick_ok) begin
                    fsm_nx     = S_ERASE;
                    scan_start = 1'b1;
                    pending_nx = 1'b0;
                end
            end
            S_ERASE: begin
                if (scan_done_c) fsm_nx = S_UPDATE;
            end
            S_UPDATE: begin
                fsm_nx     = S_DRAW_SPR;
                scan_start = 1'b1;
            end
            default: begin
                if (scan_done_c) fsm_nx = S_IDLE;
            end
        endcase

        if (fsm != S_IDLE && tick_ok) pending_nx = 1'b1;
    end

    sprite_scan #(.SIZE(SIZE)) u_scan (
        .clk      (clk),
        .reset    (reset),
        .start    (scan_start),
        .row_nx_c (scan_row_c),
        .col_nx_c (scan_col_c),
        .done_c   (scan_done_c)
    );

    // Plot port values for the cycle the sequencer is about to enter
    always_comb begin
        plot_nx   = (fsm_nx == S_ERASE) || (fsm_nx == S_DRAW_SPR);
        busy_nx   = (fsm_nx != S_IDLE);
        colour_nx = (fsm_nx == S_DRAW_SPR) ? BIRD_COLOUR : BG_COLOUR;
        x_nx      = x;
        y_nx      = y;
        if (plot_nx) begin
            x_nx = X_W'(X_POS) + X_W'(scan_col_c);
            y_nx = bird_y_nx + Y_W'(scan_row_c);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm      <= S_IDLE;
            dir      <= DIR_HOLD;
            repos    <= 1'b0;
            pending  <= 1'b0;
            rise_cnt <= '0;
            flag     <= 1'b0;
            bird_y   <= Y_W'(START_Y);
            plot     <= 1'b0;
            busy     <= 1'b0;
            x        <= '0;
            y        <= '0;
            colour   <= BG_COLOUR;
        end else begin
            fsm      <= fsm_nx;
            dir      <= dir_nx;
            repos    <= repos_nx;
            pending  <= pending_nx;
            rise_cnt <= rise_nx;
            flag     <= flag_nx;
            bird_y   <= bird_y_nx;
            plot     <= plot_nx;
            busy     <= busy_nx;
            x        <= x_nx;
            y        <= y_nx;
            colour   <= colour_nx;
        end
    end

endmodule

// File: tb/tb_bird_datapath.sv
// Scoreboard bench for bird_datapath: expected pixels are queued per tick and
// popped as plot strobes appear; position/flag/floor checked after each sequence.
module tb_bird_datapath;
    import bird_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] state;
    logic       frame_tick;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, flag, hit_floor, busy;
    logic [6:0] bird_y;

    always #5 clk = ~clk;

    bird_datapath dut (
        .clk        (clk),
        .reset      (reset),
        .state      (state),
        .frame_tick (frame_tick),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .flag       (flag),
        .hit_floor  (hit_floor),
        .busy       (busy),
        .bird_y     (bird_y)
    );

    int n_vec = 0;
    int n_err = 0;
    int plot_cnt = 0;
    int busy_cnt = 0;
    logic [17:0] pix_q[$];

    // reference model state
    int   m_y, m_rise, m_step, m_dir;
    logic m_flag, m_repos;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (busy) busy_cnt++;
            if (plot) begin
                plot_cnt++;
                if (pix_q.size() == 0) begin
                    check("plot_extra", 32'd1, 32'd0);
                end else begin
                    logic [17:0] e;
                    e = pix_q.pop_front();
                    check("pixel", {14'd0, x, y, colour}, {14'd0, e});
                end
            end
        end
    end

    task automatic step_clk;
        @(posedge clk);
        #1;
    endtask

    task automatic set_state(input logic [3:0] s);
        state = s;
        case (s)
            B_RAISING: begin m_dir = 1; m_step = 1; end
            B_FALLING: begin m_dir = 2; m_rise = 0; m_flag = 1'b0; end
            B_STOP:    m_dir = 0;
            B_START:   begin m_dir = 0; m_rise = 0; m_flag = 1'b0; m_repos = 1'b1; m_step = 1; end
            default:   ;
        endcase
    endtask

    task automatic push_sprite(input int yy, input logic [2:0] col);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                pix_q.push_back({8'(20 + c), 7'(yy + r), col});
    endtask

    task automatic model_update;
        int ny;
        if (m_repos) begin
            m_y = 60;
            m_repos = 1'b0;
        end else if (m_dir == 1) begin
            ny = (m_y >= 1) ? m_y - 1 : 0;
            m_rise += m_y - ny;
            if (m_rise >= 12 || ny == 0) m_flag = 1'b1;
            m_y = ny;
        end else if (m_dir == 2) begin
            ny = m_y + m_step;
            if (ny > 116) ny = 116;
            m_y = ny;
`ifdef BIRD_GRAVITY_EN
            if (m_step < 4) m_step++;
`endif
        end
    endtask

    task automatic queue_sequence;
        push_sprite(m_y, 3'b000);
        model_update();
        push_sprite(m_y, 3'b110);
    endtask

    task automatic pulse_tick;
        frame_tick = 1'b1;
        step_clk();
        frame_tick = 1'b0;
    endtask

    task automatic wait_not_busy(input string tag);
        for (int i = 0; i < 100 && busy; i++) step_clk();
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic tick_seq;
        logic accept;
        accept = (state != B_STOP) && (m_dir != 0 || m_repos);
        if (accept) queue_sequence();
        plot_cnt = 0;
        busy_cnt = 0;
        pulse_tick();
        if (state == B_START) set_state(B_STOP);
        if (accept) begin
            check("busy_rise", 32'(busy), 32'd1);
            wait_not_busy("busy_timeout");
            check("busy_cycles", 32'(busy_cnt), 32'd33);
            check("plot_cycles", 32'(plot_cnt), 32'd32);
        end else begin
            repeat (40) step_clk();
            check("ignored_plot", 32'(plot_cnt), 32'd0);
            check("ignored_busy", 32'(busy_cnt), 32'd0);
        end
        check("bird_y", 32'(bird_y), 32'(m_y));
        check("flag", 32'(flag), 32'(m_flag));
        check("hit_floor", 32'(hit_floor), 32'(m_y == 116));
        check("pix_left", 32'(pix_q.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        state = B_START;
        frame_tick = 1'b0;
        m_y = 60; m_rise = 0; m_step = 1; m_dir = 0;
        m_flag = 1'b0; m_repos = 1'b0;
        repeat (3) step_clk();

        check("rst_plot", 32'(plot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bird_y", 32'(bird_y), 32'd60);
        check("rst_flag", 32'(flag), 32'd0);
        check("rst_x", 32'(x), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_colour", 32'(colour), 32'd0);
        check("rst_hit_floor", 32'(hit_floor), 32'd0);

        // START plus tick straight out of reset
        reset = 1'b0;
        set_state(B_START);
        tick_seq();
        check("start_y", 32'(bird_y), 32'd60);

        // rise 12 pixels; flag only on the last move
        set_state(B_RAISING);
        for (int k = 0; k < 12; k++) tick_seq();
        check("rise_y", 32'(bird_y), 32'd48);
        check("rise_flag", 32'(flag), 32'd1);
        set_state(B_FALLING);
        step_clk();
        check("flag_clr", 32'(flag), 32'd0);

        // fall to the floor and clamp
        while (m_y < 114) tick_seq();
        for (int k = 0; k < 5; k++) tick_seq();
        check("floor_y", 32'(bird_y), 32'd116);
        check("floor_hit", 32'(hit_floor), 32'd1);

        // STOP ignores ticks, then START repositions
        set_state(B_STOP);
        for (int k = 0; k < 3; k++) tick_seq();
        check("stop_y", 32'(bird_y), 32'd116);
        set_state(B_START);
        tick_seq();
        check("restart_y", 32'(bird_y), 32'd60);

        // fall profile from the start row
        set_state(B_FALLING);
        for (int k = 0; k < 6; k++) tick_seq();
`ifdef BIRD_GRAVITY_EN
        check("fall6_y", 32'(bird_y), 32'd78);
`else
        check("fall6_y", 32'(bird_y), 32'd66);
`endif

        // two ticks 3 cycles apart plus a dropped third
        queue_sequence();
        queue_sequence();
        plot_cnt = 0;
        busy_cnt = 0;
        pulse_tick();
        step_clk();
        step_clk();
        pulse_tick();
        repeat (10) step_clk();
        pulse_tick();
        wait_not_busy("b2b_timeout1");
        for (int i = 0; i < 3 && !busy; i++) step_clk();
        check("b2b_restart", 32'(busy), 32'd1);
        wait_not_busy("b2b_timeout2");
        repeat (40) step_clk();
        check("b2b_plot", 32'(plot_cnt), 32'd64);
        check("b2b_busy", 32'(busy_cnt), 32'd66);
        check("b2b_y", 32'(bird_y), 32'(m_y));
        check("b2b_pix_left", 32'(pix_q.size()), 32'd0);

        // reset in the middle of a sequence
        queue_sequence();
        pulse_tick();
        repeat (5) step_clk();
        reset = 1'b1;
        step_clk();
        check("midrst_plot", 32'(plot), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_y", 32'(bird_y), 32'd60);
        pix_q.delete();
        m_y = 60; m_rise = 0; m_step = 1; m_dir = 0;
        m_flag = 1'b0; m_repos = 1'b0;
        reset = 1'b0;
        set_state(B_FALLING);
        step_clk();
        check("midrst_idle", 32'(plot), 32'd0);
        tick_seq();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
